// File: rtl/sevenseg_scan_decoder_pkg.sv
// Shared definitions for the seven-segment scan decoder.
// Holds the active-high glyph constants (bit0 = segment a ... bit6 = segment g)
// used by both the hex-to-seven-segment encoder and this receive-side decoder,
// plus the blank and dash patterns.
package sevenseg_scan_decoder_pkg;

    localparam logic [6:0] GLYPH_0   = 7'h3F;
    localparam logic [6:0] GLYPH_1   = 7'h06;
    localparam logic [6:0] GLYPH_2   = 7'h5B;
    localparam logic [6:0] GLYPH_3   = 7'h4F;
    localparam logic [6:0] GLYPH_4   = 7'h66;
    localparam logic [6:0] GLYPH_5   = 7'h6D;
    localparam logic [6:0] GLYPH_6   = 7'h7D;
    localparam logic [6:0] GLYPH_7   = 7'h07;
    localparam logic [6:0] GLYPH_8   = 7'h7F;
    localparam logic [6:0] GLYPH_9   = 7'h6F;
    localparam logic [6:0] GLYPH_A   = 7'h77;
    localparam logic [6:0] GLYPH_B   = 7'h7C;
    localparam logic [6:0] GLYPH_C   = 7'h39;
    localparam logic [6:0] GLYPH_D   = 7'h5E;
    localparam logic [6:0] GLYPH_E   = 7'h79;
    localparam logic [6:0] GLYPH_F   = 7'h71;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_DASH  = 7'h40;

endpackage

// File: rtl/sevenseg_pattern_decode.sv
// Combinational seven-segment pattern decoder.
// Ports:
//   p        - active-high segment pattern (bit0 = a ... bit6 = g)
//   nibble   - decoded hex value (0 when the pattern is not a hex glyph)
//   is_hex   - 1 when p is one of the 16 hex glyphs
//   is_blank - 1 when all segments are off
module sevenseg_pattern_decode
    import sevenseg_scan_decoder_pkg::*;
(
    input  logic [6:0] p,
    output logic [3:0] nibble,
    output logic       is_hex,
    output logic       is_blank
);

    // Pattern lookup; anything not listed is an unknown glyph.
    always_comb begin
        nibble   = 4'h0;
        is_hex   = 1'b1;
        is_blank = 1'b0;
        case (p)
            GLYPH_0:   nibble = 4'h0;
            GLYPH_1:   nibble = 4'h1;
            GLYPH_2:   nibble = 4'h2;
            GLYPH_3:   nibble = 4'h3;
            GLYPH_4:   nibble = 4'h4;
            GLYPH_5:   nibble = 4'h5;
            GLYPH_6:   nibble = 4'h6;
            GLYPH_7:   nibble = 4'h7;
            GLYPH_8:   nibble = 4'h8;
            GLYPH_9:   nibble = 4'h9;
            GLYPH_A:   nibble = 4'hA;
            GLYPH_B:   nibble = 4'hB;
            GLYPH_C:   nibble = 4'hC;
            GLYPH_D:   nibble = 4'hD;
            GLYPH_E:   nibble = 4'hE;
            GLYPH_F:   nibble = 4'hF;
            SEG_BLANK: begin
                is_hex   = 1'b0;
                is_blank = 1'b1;
            end
            // The dash is a common "no data" glyph but carries no nibble.
            SEG_DASH:  is_hex = 1'b0;
            default:   is_hex = 1'b0;
        endcase
    end

endmodule

// File: rtl/sevenseg_scan_decoder.sv
// Receive-side decoder for a multiplexed, active-low seven-segment bus.
// Synchronises segment and digit-select lines, waits for a digit's pattern to
// be stable for STABLE_CYCLES samples, then commits the decoded nibble.
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   seg_n        - active-low segments (bit0 = a ... bit6 = g)
//   dig_n        - active-low digit selects, bit i = digit i
//   value        - decoded nibbles, digit i at value[4i+3:4i]
//   digit_valid  - digit i last committed a hex glyph
//   digit_err    - digit i last committed an unknown pattern
//   frame_done   - one-cycle pulse once every digit has committed
module sevenseg_scan_decoder
    import sevenseg_scan_decoder_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg_n,
    input  logic [NUM_DIGITS-1:0]   dig_n,
    output logic [4*NUM_DIGITS-1:0] value,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic [NUM_DIGITS-1:0]   digit_err,
    output logic                    frame_done
);

    localparam int                    CNT_W   = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]      CNT_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0]      CNT_ONE = CNT_W'(1);
    localparam logic [NUM_DIGITS-1:0] ONE_D   = NUM_DIGITS'(1);

    logic [SYNC_STAGES-1:0][6:0]            seg_sync_q, seg_sync_d;
    logic [SYNC_STAGES-1:0][NUM_DIGITS-1:0] dig_sync_q, dig_sync_d;
    logic [6:0]              prev_seg_q;
    logic [NUM_DIGITS-1:0]   prev_dig_q;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0]   upd_mask_q, upd_mask_d;
    logic [4*NUM_DIGITS-1:0] value_q, value_d;
    logic [NUM_DIGITS-1:0]   digit_valid_q, digit_valid_d;
    logic [NUM_DIGITS-1:0]   digit_err_q, digit_err_d;
    logic                    frame_done_q, frame_done_d;

    logic [6:0]            s_seg;
    logic [NUM_DIGITS-1:0] s_dig;
    logic [6:0]            pattern_s;
    logic [NUM_DIGITS-1:0] dig_act_s;
    logic                  sel_s;
    logic                  same_s;
    logic                  commit_s;
    logic [NUM_DIGITS-1:0] commit_vec_s;
    logic [NUM_DIGITS-1:0] mask_s;
    logic [3:0]            nibble_s;
    logic                  is_hex_s;
    logic                  is_blank_s;

    assign s_seg     = seg_sync_q[SYNC_STAGES-1];
    assign s_dig     = dig_sync_q[SYNC_STAGES-1];
    assign pattern_s = ~s_seg;

    sevenseg_pattern_decode u_decode (
        .p        (pattern_s),
        .nibble   (nibble_s),
        .is_hex   (is_hex_s),
        .is_blank (is_blank_s)
    );

    // Synchroniser shift: stage 0 takes the pins, later stages follow.
    always_comb begin
        seg_sync_d = {seg_sync_q[SYNC_STAGES-2:0], seg_n};
        dig_sync_d = {dig_sync_q[SYNC_STAGES-2:0], dig_n};
    end

    // Selection, stability run counter and commit decision.
    always_comb begin
        dig_act_s = ~s_dig;
        // Exactly one active select: non-zero and a power of two.
        sel_s  = (dig_act_s != '0) && ((dig_act_s & (dig_act_s - ONE_D)) == '0);
        same_s = (s_dig == prev_dig_q) && (s_seg == prev_seg_q);
        if (!sel_s) begin
            cnt_d = '0;
        end else if (!same_s) begin
            cnt_d = CNT_ONE;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = CNT_MAX;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
        // A saturated run holding the same sample must not commit again.
        commit_s     = sel_s && (cnt_d == CNT_MAX) && !(same_s && (cnt_q == CNT_MAX));
        commit_vec_s = commit_s ? dig_act_s : '0;
    end

    // Per-digit output update and frame completion tracking.
    always_comb begin
        value_d       = value_q;
        digit_valid_d = digit_valid_q;
        digit_err_d   = digit_err_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (commit_vec_s[i]) begin
                if (is_hex_s) begin
                    value_d[4*i +: 4] = nibble_s;
                    digit_valid_d[i]  = 1'b1;
                    digit_err_d[i]    = 1'b0;
                end else if (is_blank_s) begin
                    value_d[4*i +: 4] = 4'h0;
                    digit_valid_d[i]  = 1'b0;
                    digit_err_d[i]    = 1'b0;
                end else begin
                    // Unknown glyph keeps the last good nibble.
                    digit_valid_d[i]  = 1'b0;
                    digit_err_d[i]    = 1'b1;
                end
            end else begin
                value_d[4*i +: 4] = value_q[4*i +: 4];
            end
        end
        mask_s = upd_mask_q | commit_vec_s;
        if (mask_s == '1) begin
            frame_done_d = 1'b1;
            upd_mask_d   = '0;
        end else begin
            frame_done_d = 1'b0;
            upd_mask_d   = mask_s;
        end
    end

    // State registers; synchroniser and history idle at all-ones (inactive).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_sync_q    <= '1;
            dig_sync_q    <= '1;
            prev_seg_q    <= '1;
            prev_dig_q    <= '1;
            cnt_q         <= '0;
            upd_mask_q    <= '0;
            value_q       <= '0;
            digit_valid_q <= '0;
            digit_err_q   <= '0;
            frame_done_q  <= 1'b0;
        end else begin
            seg_sync_q    <= seg_sync_d;
            dig_sync_q    <= dig_sync_d;
            prev_seg_q    <= s_seg;
            prev_dig_q    <= s_dig;
            cnt_q         <= cnt_d;
            upd_mask_q    <= upd_mask_d;
            value_q       <= value_d;
            digit_valid_q <= digit_valid_d;
            digit_err_q   <= digit_err_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign value       = value_q;
    assign digit_valid = digit_valid_q;
    assign digit_err   = digit_err_q;
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// Directed self-checking bench for sevenseg_scan_decoder (4 digits,
// STABLE_CYCLES=4, SYNC_STAGES=2, so commits land 6 edges after a pin change).
module tb_sevenseg_scan_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  seg_n = 7'h7F;
    logic [3:0]  dig_n = 4'hF;
    logic [15:0] value;
    logic [3:0]  digit_valid;
    logic [3:0]  digit_err;
    logic        frame_done;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          fd_cnt  = 0;
    logic [15:0] fd_value = 16'h0000;

    sevenseg_scan_decoder #(
        .NUM_DIGITS    (4),
        .STABLE_CYCLES (4),
        .SYNC_STAGES   (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_n       (seg_n),
        .dig_n       (dig_n),
        .value       (value),
        .digit_valid (digit_valid),
        .digit_err   (digit_err),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    // Count frame_done pulses mid-cycle and remember the value seen with each.
    always @(negedge clk) begin
        if (frame_done === 1'b1) begin
            fd_cnt   = fd_cnt + 1;
            fd_value = value;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] sel_n(input int d);
        logic [3:0] t;
        t = 4'b0001 << d;
        return ~t;
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        step(2);
        n_tests++; if (value !== 16'h0000) begin n_fail++; $display("FAIL reset_value got %h want 0000", value); end
        n_tests++; if (digit_valid !== 4'h0) begin n_fail++; $display("FAIL reset_valid got %b want 0000", digit_valid); end
        n_tests++; if (digit_err !== 4'h0) begin n_fail++; $display("FAIL reset_err got %b want 0000", digit_err); end
        n_tests++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
        rst = 1'b0;
        step(2);
    endtask

    task automatic test_single_digit;
        int fd0;
        dig_n = 4'b1110;
        seg_n = 7'h30;
        step(5);
        n_tests++; if (value !== 16'h0000) begin n_fail++; $display("FAIL single_early got %h want 0000", value); end
        step(1);
        n_tests++; if (value !== 16'h0003) begin n_fail++; $display("FAIL single_value got %h want 0003", value); end
        n_tests++; if (digit_valid !== 4'b0001) begin n_fail++; $display("FAIL single_valid got %b want 0001", digit_valid); end
        n_tests++; if (digit_err !== 4'b0000) begin n_fail++; $display("FAIL single_err got %b want 0000", digit_err); end
        fd0 = fd_cnt;
        step(10);
        n_tests++; if (value !== 16'h0003) begin n_fail++; $display("FAIL single_hold got %h want 0003", value); end
        n_tests++; if (fd_cnt !== fd0) begin n_fail++; $display("FAIL single_no_frame got %0d want %0d", fd_cnt, fd0); end
    endtask

    task automatic test_reset_mid;
        // Pins still drive a stable "3" on digit 0.
        #2 rst = 1'b1;
        #1;
        n_tests++; if (value !== 16'h0000) begin n_fail++; $display("FAIL midrst_value got %h want 0000", value); end
        n_tests++; if (digit_valid !== 4'h0) begin n_fail++; $display("FAIL midrst_valid got %b want 0000", digit_valid); end
        step(2);
        rst = 1'b0;
        step(5);
        n_tests++; if (value !== 16'h0000) begin n_fail++; $display("FAIL midrst_early got %h want 0000", value); end
        step(1);
        n_tests++; if (value !== 16'h0003) begin n_fail++; $display("FAIL midrst_commit got %h want 0003", value); end
    endtask

    task automatic test_scan;
        logic [6:0] tbl [4];
        int fd0;
        tbl = '{7'h40, 7'h08, 7'h21, 7'h0E};
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        fd0 = fd_cnt;
        for (int d = 0; d < 4; d++) begin
            dig_n = sel_n(d);
            seg_n = tbl[d];
            step(8);
        end
        dig_n = 4'hF;
        step(4);
        n_tests++; if (value !== 16'hFDA0) begin n_fail++; $display("FAIL scan_value got %h want FDA0", value); end
        n_tests++; if (digit_valid !== 4'hF) begin n_fail++; $display("FAIL scan_valid got %b want 1111", digit_valid); end
        n_tests++; if (digit_err !== 4'h0) begin n_fail++; $display("FAIL scan_err got %b want 0000", digit_err); end
        n_tests++; if (fd_cnt !== fd0 + 1) begin n_fail++; $display("FAIL scan_frames got %0d want %0d", fd_cnt - fd0, 1); end
        n_tests++; if (fd_value !== 16'hFDA0) begin n_fail++; $display("FAIL scan_frame_value got %h want FDA0", fd_value); end
    endtask

    task automatic test_unknown_blank;
        dig_n = 4'b1011;
        seg_n = 7'h3F;
        step(8);
        n_tests++; if (digit_err[2] !== 1'b1) begin n_fail++; $display("FAIL dash_err got %b want 1", digit_err[2]); end
        n_tests++; if (digit_valid[2] !== 1'b0) begin n_fail++; $display("FAIL dash_valid got %b want 0", digit_valid[2]); end
        n_tests++; if (value !== 16'hFDA0) begin n_fail++; $display("FAIL dash_retain got %h want FDA0", value); end
        seg_n = 7'h7F;
        step(8);
        n_tests++; if (digit_err[2] !== 1'b0) begin n_fail++; $display("FAIL blank_err got %b want 0", digit_err[2]); end
        n_tests++; if (digit_valid !== 4'b1011) begin n_fail++; $display("FAIL blank_valid got %b want 1011", digit_valid); end
        n_tests++; if (value !== 16'hF0A0) begin n_fail++; $display("FAIL blank_value got %h want F0A0", value); end
    endtask

    task automatic test_instability;
        int fd0;
        fd0 = fd_cnt;
        dig_n = 4'b1110;
        for (int i = 0; i < 8; i++) begin
            seg_n = (i % 2 == 0) ? 7'h79 : 7'h24;
            step(3);
        end
        n_tests++; if (value !== 16'hF0A0) begin n_fail++; $display("FAIL toggle_value got %h want F0A0", value); end
        n_tests++; if (digit_valid !== 4'b1011) begin n_fail++; $display("FAIL toggle_valid got %b want 1011", digit_valid); end
        dig_n = 4'b1100;
        seg_n = 7'h79;
        step(10);
        n_tests++; if (value !== 16'hF0A0) begin n_fail++; $display("FAIL multisel_value got %h want F0A0", value); end
        n_tests++; if (fd_cnt !== fd0) begin n_fail++; $display("FAIL multisel_frame got %0d want %0d", fd_cnt, fd0); end
        dig_n = 4'b1110;
        step(5);
        n_tests++; if (value !== 16'hF0A0) begin n_fail++; $display("FAIL resel_early got %h want F0A0", value); end
        step(1);
        n_tests++; if (value !== 16'hF0A1) begin n_fail++; $display("FAIL resel_commit got %h want F0A1", value); end
    endtask

    task automatic test_ghost;
        logic [6:0] own [4];
        logic [3:0] ghost_nib [4];
        logic [3:0] got;
        int fd0;
        own       = '{7'h79, 7'h24, 7'h30, 7'h19};
        ghost_nib = '{4'h4, 4'h1, 4'h2, 4'h3};
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        fd0 = fd_cnt;
        for (int r = 0; r < 2; r++) begin
            for (int d = 0; d < 4; d++) begin
                dig_n = sel_n(d);
                seg_n = own[(d + 3) % 4];
                for (int c = 0; c < 8; c++) begin
                    if (c == 2) seg_n = own[d];
                    step(1);
                    got = value[4*d +: 4];
                    n_tests++;
                    if (got === ghost_nib[d]) begin
                        n_fail++;
                        $display("FAIL ghost_commit digit %0d got %h must not be %h", d, got, ghost_nib[d]);
                    end
                end
            end
        end
        dig_n = 4'hF;
        step(4);
        n_tests++; if (value !== 16'h4321) begin n_fail++; $display("FAIL ghost_value got %h want 4321", value); end
        n_tests++; if (digit_valid !== 4'hF) begin n_fail++; $display("FAIL ghost_valid got %b want 1111", digit_valid); end
        n_tests++; if (fd_cnt !== fd0 + 2) begin n_fail++; $display("FAIL ghost_frames got %0d want %0d", fd_cnt - fd0, 2); end
    endtask

    initial begin
        test_reset();
        test_single_digit();
        test_reset_mid();
        test_scan();
        test_unknown_blank();
        test_instability();
        test_ghost();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
